// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the core load/store port with RV32 lane rules,
// programmable wait states and error reporting.
module dmem_responder #(
  parameter int unsigned ADDR_BITS   = 9,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter string       DATA_FILE   = "Data.hex"
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWe,
  input  logic [31:0] ReqAddr,
  input  logic [2:0]  ReqFunct3,
  input  logic [31:0] ReqWdata,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspRdata,
  output logic        RspErr
);

  localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH];

  logic        req_we;
  logic [31:0] req_off;
  logic [2:0]  req_f3;
  logic [31:0] req_wdata;
  logic [3:0]  wait_cnt;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic                 accept;
  logic                 commit;
  logic                 acc_we;
  logic [31:0]          acc_off;
  logic [2:0]           acc_f3;
  logic [31:0]          acc_wdata;
  logic                 acc_err;
  logic [ADDR_BITS-1:0] acc_idx;
  logic [31:0]          acc_word;

  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [31:0] off);
    logic bad_f3;
    logic misal;
    logic oor;
    if (we) bad_f3 = f3[2] || (f3[1:0] == 2'b11);
    else    bad_f3 = (f3[1:0] == 2'b11) || (f3 == 3'b110);
    misal = ((f3[1:0] == 2'b01) && off[0]) ||
            ((f3[1:0] == 2'b10) && (off[1:0] != 2'b00));
    oor   = |(off >> (ADDR_BITS + 2));
    return bad_f3 || misal || oor;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    case (f3[1:0])
      2'b00:   m[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) m[31:16] = wdata[15:0];
        else         m[15:0]  = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  // With zero wait states the access commits on the accept edge, so it uses the live request.
  always_comb begin
    if (state == S_IDLE) begin
      acc_we    = ReqWe;
      acc_off   = ReqAddr - BASE_ADDR;
      acc_f3    = ReqFunct3;
      acc_wdata = ReqWdata;
    end else begin
      acc_we    = req_we;
      acc_off   = req_off;
      acc_f3    = req_f3;
      acc_wdata = req_wdata;
    end
  end

  assign acc_idx  = acc_off[ADDR_BITS+1:2];
  assign acc_word = mem[acc_idx];
  assign acc_err  = access_err(acc_we, acc_f3, acc_off);

  always_comb begin
    state_next = state;
    ReqReady   = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        ReqReady = !Reset;
        accept   = ReqValid && !Reset;
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = S_RESP;
            commit     = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = S_RESP;
          commit     = 1'b1;
        end
      end
      S_RESP: begin
        if (RspReady) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_cnt  <= 4'd0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept)
        wait_cnt <= WAIT_INIT;
      else if ((state == S_WAIT) && (wait_cnt != 4'd0))
        wait_cnt <= wait_cnt - 4'd1;
      // Response is captured once on entry to RESP and held until the handshake.
      if (commit) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? 32'h0 : load_ext(acc_word, acc_f3, acc_off[1:0]);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      req_we    <= ReqWe;
      req_off   <= acc_off;
      req_f3    <= ReqFunct3;
      req_wdata <= ReqWdata;
    end
  end

  // A reset arriving before the commit edge drops the store.
  always_ff @(posedge Clk) begin
    if (commit && !Reset && acc_we && !acc_err)
      mem[acc_idx] <= store_merge(acc_word, acc_wdata, acc_f3, acc_off[1:0]);
  end

  assign RspValid = (state == S_RESP) && !Reset;
  assign RspRdata = rsp_rdata;
  assign RspErr   = rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: unit 0 has one wait state, unit 1 has three.
module tb_dmem_responder;

  typedef struct {
    int          unit;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [1:0]  reset, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_f3    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  dmem_responder #(.ADDR_BITS(9), .WAIT_STATES(1), .BASE_ADDR(32'h0), .DATA_FILE("")) dut1 (
    .Clk(Clk), .Reset(reset[0]), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
    .ReqWe(req_we[0]), .ReqAddr(req_addr[0]), .ReqFunct3(req_f3[0]), .ReqWdata(req_wdata[0]),
    .RspValid(rsp_valid[0]), .RspReady(rsp_ready[0]), .RspRdata(rsp_rdata[0]), .RspErr(rsp_err[0])
  );

  dmem_responder #(.ADDR_BITS(9), .WAIT_STATES(3), .BASE_ADDR(32'h0), .DATA_FILE("")) dut3 (
    .Clk(Clk), .Reset(reset[1]), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
    .ReqWe(req_we[1]), .ReqAddr(req_addr[1]), .ReqFunct3(req_f3[1]), .ReqWdata(req_wdata[1]),
    .RspValid(rsp_valid[1]), .RspReady(rsp_ready[1]), .RspRdata(rsp_rdata[1]), .RspErr(rsp_err[1])
  );

  // Monitor: every response handshake is matched against the oldest expectation.
  always @(negedge Clk) begin : monitor
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (rsp_valid[u] && rsp_ready[u]) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp unit=%0d got rdata=%h err=%b, required no response",
                   u, rsp_rdata[u], rsp_err[u]);
        end else begin
          e = sb.pop_front();
          if (e.unit != u || rsp_rdata[u] !== e.rdata || rsp_err[u] !== e.err) begin
            failures++;
            $display("FAIL %s: got unit=%0d rdata=%h err=%b, required unit=%0d rdata=%h err=%b",
                     e.name, u, rsp_rdata[u], rsp_err[u], e.unit, e.rdata, e.err);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic drive(input int u, input logic we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_f3[u]    = f3;
    req_wdata[u] = wd;
  endtask

  // Returns just after the accepting edge.
  task automatic accept(input int u, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e,
                        input string nm, input bit push);
    int n = 0;
    drive(u, we, addr, f3, wd);
    @(negedge Clk);
    while (!req_ready[u] && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready[u]) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout: got ReqReady=0 required 1", nm);
    end else if (push) begin
      sb.push_back('{unit: u, rdata: exp_d, err: exp_e, name: nm});
    end
    @(posedge Clk);
    #1;
    req_valid[u] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic txn(input int u, input logic we, input logic [31:0] addr,
                     input logic [2:0] f3, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e, input string nm);
    accept(u, we, addr, f3, wd, exp_d, exp_e, nm, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 2'b11;
    req_valid = 2'b00;
    req_we    = 2'b00;
    rsp_ready = 2'b11;
    for (int u = 0; u < 2; u++) begin
      req_f3[u]    = 3'b000;
      req_addr[u]  = 32'h0;
      req_wdata[u] = 32'h0;
    end

    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_ready_u%0d", u), req_ready[u], 0);
      chk($sformatf("rst_rspvalid_u%0d", u), rsp_valid[u], 0);
      chk($sformatf("rst_rdata_u%0d", u), rsp_rdata[u], 0);
      chk($sformatf("rst_err_u%0d", u), rsp_err[u], 0);
    end
    @(posedge Clk);
    #1;
    reset = 2'b00;
    @(negedge Clk);
    chk("idle_ready_u0", req_ready[0], 1);
    chk("idle_ready_u1", req_ready[1], 1);
    @(posedge Clk);
    #1;

    // T1: latency with one wait state, then read back
    accept(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, "t1_sw", 1'b1);
    @(negedge Clk);
    chk("t1_wait_cycle_valid", rsp_valid[0], 0);
    @(negedge Clk);
    chk("t1_rsp_cycle_valid", rsp_valid[0], 1);
    drain();
    txn(0, 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, "t1_lw");

    // T2: byte store and sign/zero-extended byte loads
    txn(0, 1'b1, 32'h13, 3'b000, 32'h00000080, 32'h0, 1'b0, "t2_sb");
    txn(0, 1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0, "t2_lb");
    txn(0, 1'b0, 32'h13, 3'b100, 32'h0, 32'h00000080, 1'b0, "t2_lbu");
    txn(0, 1'b0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0, "t2_lw");

    // T3: misaligned accesses error and leave memory untouched
    txn(0, 1'b1, 32'h11, 3'b001, 32'h00001234, 32'h0, 1'b1, "t3_sh_misal");
    txn(0, 1'b0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0, "t3_lw_unchanged");
    txn(0, 1'b0, 32'h12, 3'b010, 32'h0, 32'h0, 1'b1, "t3_lw_misal");

    // T4: response backpressure with a competing request
    rsp_ready[0] = 1'b0;
    accept(0, 1'b0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0, "t4_lw", 1'b1);
    n = 0;
    @(negedge Clk);
    while (!rsp_valid[0] && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("t4_rsp_arrived", rsp_valid[0], 1);
    drive(0, 1'b1, 32'h14, 3'b010, 32'h11223344);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk($sformatf("t4_hold_valid_%0d", i), rsp_valid[0], 1);
      chk($sformatf("t4_hold_rdata_%0d", i), rsp_rdata[0], 32'h80ADBEEF);
      chk($sformatf("t4_hold_err_%0d", i), rsp_err[0], 0);
      chk($sformatf("t4_hold_ready_%0d", i), req_ready[0], 0);
    end
    @(posedge Clk);
    #1;
    rsp_ready[0] = 1'b1;
    @(negedge Clk);
    chk("t4_ready_in_handshake", req_ready[0], 0);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("t4_ready_after_handshake", req_ready[0], 1);
    sb.push_back('{unit: 0, rdata: 32'h0, err: 1'b0, name: "t4_sw_pending"});
    @(posedge Clk);
    #1;
    req_valid[0] = 1'b0;
    drain();
    txn(0, 1'b0, 32'h14, 3'b010, 32'h0, 32'h11223344, 1'b0, "t4_lw_pending");

    // T5: range, illegal funct3 and half/byte extension boundaries
    txn(0, 1'b0, 32'h800, 3'b010, 32'h0, 32'h0, 1'b1, "t5_lw_oor");
    txn(0, 1'b0, 32'h0, 3'b011, 32'h0, 32'h0, 1'b1, "t5_lw_f3_011");
    txn(0, 1'b0, 32'h0, 3'b110, 32'h0, 32'h0, 1'b1, "t5_ld_f3_110");
    txn(0, 1'b1, 32'h0, 3'b011, 32'h5555AAAA, 32'h0, 1'b1, "t5_st_f3_011");
    txn(0, 1'b1, 32'h800, 3'b000, 32'h000000FF, 32'h0, 1'b1, "t5_sb_oor");
    txn(0, 1'b1, 32'h7FC, 3'b010, 32'hA5A50001, 32'h0, 1'b0, "t5_sw_top");
    txn(0, 1'b0, 32'h7FC, 3'b010, 32'h0, 32'hA5A50001, 1'b0, "t5_lw_top");
    txn(0, 1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFF80AD, 1'b0, "t5_lh_hi");
    txn(0, 1'b0, 32'h12, 3'b101, 32'h0, 32'h000080AD, 1'b0, "t5_lhu_hi");
    txn(0, 1'b0, 32'h10, 3'b001, 32'h0, 32'hFFFFBEEF, 1'b0, "t5_lh_lo");
    txn(0, 1'b0, 32'h10, 3'b000, 32'h0, 32'hFFFFFFEF, 1'b0, "t5_lb_lo");
    txn(0, 1'b1, 32'h16, 3'b001, 32'h0000ABCD, 32'h0, 1'b0, "t5_sh_hi");
    txn(0, 1'b0, 32'h14, 3'b010, 32'h0, 32'hABCD3344, 1'b0, "t5_lw_after_sh");

    // T6: reset mid-wait drops an uncommitted store
    txn(1, 1'b1, 32'h20, 3'b010, 32'h01020304, 32'h0, 1'b0, "t6_sw_prior");
    accept(1, 1'b1, 32'h20, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0, "t6_sw_dropped", 1'b0);
    @(posedge Clk);
    #1;
    reset[1] = 1'b1;
    @(negedge Clk);
    chk("t6_ready_in_reset", req_ready[1], 0);
    @(posedge Clk);
    #1;
    reset[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk($sformatf("t6_no_rsp_%0d", i), rsp_valid[1], 0);
    end
    chk("t6_ready_after_reset", req_ready[1], 1);
    @(posedge Clk);
    #1;
    txn(1, 1'b0, 32'h20, 3'b010, 32'h0, 32'h01020304, 1'b0, "t6_lw_prior");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
